writeback_arbiter: RTL
======================

# writeback_arbiter

Merges register-file writeback traffic from two result producers, the ALU and the load/store unit (LSU), onto the single register-file write port. Each producer hands results over a valid/ready channel into its own small FIFO. A round-robin arbiter drains the FIFO heads into a registered write port. The block also reports per-register "write pending" status on two lookup ports so issue logic can stall on RAW/WAW hazards until the write has landed.

## Interface
Parameters:
- DEPTH, 2, entries per source FIFO; power of two, ≥2.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ALU_VALID  in  1  ALU result offered.
- ALU_READY  out  1  ALU FIFO can accept.
- ALU_REG  in  5  ALU destination register.
- ALU_DATA  in  32  ALU result.
- LSU_VALID  in  1  LSU result offered.
- LSU_READY  out  1  LSU FIFO can accept.
- LSU_REG  in  5  LSU destination register.
- LSU_DATA  in  32  LSU result.
- WRITE_ENABLE  out  1  register-file write strobe.
- WRITE_REG  out  5  register-file write address.
- WRITE_DATA  out  32  register-file write data.
- LOOKUP_REG_1, LOOKUP_REG_2  in  5 each  registers queried by issue logic.
- PENDING_1, PENDING_2  out  1 each  a queued or in-flight write targets the looked-up register.

## Operation
- Transfer on a source: VALID && READY at a rising edge.
- READY = FIFO not full. It does not depend on VALID, and it gives no credit for a pop in the same cycle.
- A transfer with REG == 0 is accepted but not enqueued. It never produces a write.
- Each FIFO preserves order within its source. Simultaneous push and pop on a non-full FIFO are both performed.
- Arbitration happens every cycle over the FIFO heads:
  - Only one head non-empty: pop it.
  - Both non-empty: pop the source not granted last. LAST_GRANT updates only on a pop.
  - Neither non-empty: no pop.
- Output register:
  - On a pop: loads WRITE_ENABLE=1 with the popped REG/DATA.
  - Otherwise: WRITE_ENABLE=0, WRITE_REG=0, WRITE_DATA=0.
- PENDING_n=1 iff LOOKUP_REG_n != 0 and it matches any of:
  - a valid entry in either FIFO;
  - the output register while WRITE_ENABLE=1.
- PENDING is combinational from current state and the lookup inputs. It does not include same-cycle incoming transfers.
- There is no ordering guarantee between ALU and LSU writes to the same register. Issue logic uses PENDING to avoid this case.

## Timing
- Reset (RST_N low, asynchronous):
  - FIFOs empty; LAST_GRANT=LSU, so the first tie goes to the ALU.
  - WRITE_ENABLE=0, WRITE_REG=0, WRITE_DATA=0.
  - ALU_READY=LSU_READY=1; PENDING_1=PENDING_2=0.
- Reset asserted mid-operation discards all queued and in-flight entries. Nothing is written.
- Latency, uncontended: transfer at edge N, entry popped and output registered at edge N+1, register file samples at edge N+2. PENDING is high from after edge N until edge N+2.
- Throughput: one write per cycle total. Each source sustains one per cycle only when it is the sole active source.
- Both sources valid every cycle: grants alternate ALU, LSU, ALU, and so on. Each source fills at most to full, and READY deasserts only while its FIFO is full.

## Structure
- Shared package `wb_pkg`:
  - REG_ADDR_W=5, XLEN=32;
  - source-ID constants SRC_ALU=0, SRC_LSU=1;
  - an entry typedef {reg[4:0], data[31:0]}.
- One sub-module `wb_fifo`, instantiated twice:
  - parameterised DEPTH, synchronous FIFO with async active-low reset;
  - exposes full/empty/head plus a per-entry valid+reg vector for the PENDING compare.
- The arbiter, output register and PENDING logic live in the top level.

## Test plan
- Single ALU write: ALU_REG=5, DATA=0xDEADBEEF at edge N → WRITE_ENABLE=1, REG=5, DATA=0xDEADBEEF during cycle N+1..N+2. LOOKUP_REG_1=5 gives PENDING_1=1 until edge N+2.
- x0 drop: LSU_REG=0, DATA=0x1 accepted → WRITE_ENABLE stays 0, PENDING for lookup 0 stays 0.
- Contention: both sources push 3 entries each cycle (ALU regs 1,2,3; LSU regs 11,12,13) → write order 1,11,2,12,3,13. Each READY drops only when its FIFO holds DEPTH entries.
- Backpressure: stall the LSU path by keeping the ALU saturated, fill the LSU FIFO to DEPTH=2 → LSU_READY=0. The held LSU_VALID/data is accepted the cycle after the LSU FIFO pops. No loss, no duplication.
- Async reset mid-traffic: drop RST_N between edges with 3 entries queued → outputs zero immediately. No writes occur after release; READY=1.
- Scoreboard: ALU reg 7 and LSU reg 7 queued, LOOKUP_REG_2=7 → PENDING_2=1 until the second write retires. LOOKUP_REG_2=8 → 0 throughout.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, source IDs and the queued writeback entry type
// for the register-file writeback arbiter.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source synchronous FIFO of writeback entries; exposes per-slot
// valid and destination register so the top can answer hazard lookups.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output wb_entry_t                        head,
  output logic [DEPTH-1:0]                 slot_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] slot_reg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = &slot_valid;
  assign empty   = ~|slot_valid;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Slot validity lives in its own bit per entry; push and pop never hit
  // the same slot while the FIFO is non-full and non-empty.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      slot_valid <= '0;
    end else begin
      if (pop_ok) begin
        slot_valid[rd_ptr] <= 1'b0;
        rd_ptr             <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        slot_valid[wr_ptr] <= 1'b1;
        wr_ptr             <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_reg[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin merge of ALU and LSU results onto the single register-file
// write port, with per-register pending status for issue hazard stalls.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ALU_VALID,
  output logic                  ALU_READY,
  input  logic [REG_ADDR_W-1:0] ALU_REG,
  input  logic [XLEN-1:0]       ALU_DATA,
  input  logic                  LSU_VALID,
  output logic                  LSU_READY,
  input  logic [REG_ADDR_W-1:0] LSU_REG,
  input  logic [XLEN-1:0]       LSU_DATA,
  output logic                  WRITE_ENABLE,
  output logic [REG_ADDR_W-1:0] WRITE_REG,
  output logic [XLEN-1:0]       WRITE_DATA,
  input  logic [REG_ADDR_W-1:0] LOOKUP_REG_1,
  input  logic [REG_ADDR_W-1:0] LOOKUP_REG_2,
  output logic                  PENDING_1,
  output logic                  PENDING_2
);

  logic                             alu_full, alu_empty, lsu_full, lsu_empty;
  logic                             alu_push, lsu_push;
  logic                             grant_alu, grant_lsu;
  logic                             last_grant;
  wb_entry_t                        alu_in, lsu_in, alu_head, lsu_head, pop_entry;
  logic [DEPTH-1:0]                 alu_slot_valid, lsu_slot_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] alu_slot_reg, lsu_slot_reg;

  assign ALU_READY = !alu_full;
  assign LSU_READY = !lsu_full;

  // Writes to x0 are handshaken but dropped before the FIFO.
  assign alu_push = ALU_VALID && ALU_READY && (ALU_REG != '0);
  assign lsu_push = LSU_VALID && LSU_READY && (LSU_REG != '0);
  assign alu_in   = '{rd: ALU_REG, data: ALU_DATA};
  assign lsu_in   = '{rd: LSU_REG, data: LSU_DATA};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .push       (alu_push),
    .push_entry (alu_in),
    .pop        (grant_alu),
    .full       (alu_full),
    .empty      (alu_empty),
    .head       (alu_head),
    .slot_valid (alu_slot_valid),
    .slot_reg   (alu_slot_reg)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .push       (lsu_push),
    .push_entry (lsu_in),
    .pop        (grant_lsu),
    .full       (lsu_full),
    .empty      (lsu_empty),
    .head       (lsu_head),
    .slot_valid (lsu_slot_valid),
    .slot_reg   (lsu_slot_reg)
  );

  assign grant_alu = !alu_empty && (lsu_empty || (last_grant == SRC_LSU));
  assign grant_lsu = !lsu_empty && !grant_alu;

  always_comb begin
    pop_entry = '0;
    if (grant_alu) begin
      pop_entry = alu_head;
    end else if (grant_lsu) begin
      pop_entry = lsu_head;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant   <= SRC_LSU;
      WRITE_ENABLE <= 1'b0;
      WRITE_REG    <= '0;
      WRITE_DATA   <= '0;
    end else begin
      WRITE_ENABLE <= grant_alu || grant_lsu;
      WRITE_REG    <= pop_entry.rd;
      WRITE_DATA   <= pop_entry.data;
      if (grant_alu) begin
        last_grant <= SRC_ALU;
      end else if (grant_lsu) begin
        last_grant <= SRC_LSU;
      end
    end
  end

  // WRITE_REG is zero whenever WRITE_ENABLE is low, so x0 lookups never hit.
  always_comb begin
    PENDING_1 = WRITE_ENABLE && (WRITE_REG == LOOKUP_REG_1);
    PENDING_2 = WRITE_ENABLE && (WRITE_REG == LOOKUP_REG_2);
    for (int i = 0; i < DEPTH; i++) begin
      PENDING_1 = PENDING_1
                  || (alu_slot_valid[i] && (alu_slot_reg[i] == LOOKUP_REG_1))
                  || (lsu_slot_valid[i] && (lsu_slot_reg[i] == LOOKUP_REG_1));
      PENDING_2 = PENDING_2
                  || (alu_slot_valid[i] && (alu_slot_reg[i] == LOOKUP_REG_2))
                  || (lsu_slot_valid[i] && (lsu_slot_reg[i] == LOOKUP_REG_2));
    end
    if (LOOKUP_REG_1 == '0) PENDING_1 = 1'b0;
    if (LOOKUP_REG_2 == '0) PENDING_2 = 1'b0;
  end

endmodule
